// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported memory.
// Port 0 is the CPU, port 1 the auxiliary loader/DMA; one transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int WR_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
    input  logic [1:0]           wsize0,
    input  logic [1:0]           wsize1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err0,
    output logic                 err1,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [1:0]           mem_write,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_q,
    input  logic                 mem_done,
    input  logic                 mem_align_error,
    output logic                 busy
);
    localparam int CNT_W = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_BUSY = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t             state_reg;
    logic               grant_reg;
    logic               last_grant_reg;
    logic               err_flag_reg;
    logic [CNT_W-1:0]   timeout_cnt_reg;
    logic [1:0]         ack_reg;
    logic [1:0]         err_reg;

    logic                 grant_sel;
    logic [WORD_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic [1:0]           sel_wsize;
    logic                 wr_timeout;
    logic                 resp_err;

    // Contention goes to the port not served last; a lone requester always wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1) begin
            grant_sel = ~last_grant_reg;
        end else if (req1) begin
            grant_sel = 1'b1;
        end
        sel_addr   = grant_sel ? addr1  : addr0;
        sel_wdata  = grant_sel ? wdata1 : wdata0;
        sel_wsize  = grant_sel ? wsize1 : wsize0;
        wr_timeout = (timeout_cnt_reg == CNT_W'(WR_TIMEOUT - 1));
        resp_err   = err_flag_reg | mem_align_error
                   | ((state_reg == WR_BUSY) & wr_timeout & ~mem_done);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            err_flag_reg    <= 1'b0;
            timeout_cnt_reg <= '0;
            ack_reg         <= 2'b00;
            err_reg         <= 2'b00;
            rdata           <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_write       <= 2'b00;
        end else begin
            ack_reg <= 2'b00;
            err_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_reg      <= grant_sel;
                        last_grant_reg <= grant_sel;
                        err_flag_reg   <= 1'b0;
                        mem_address    <= sel_addr;
                        mem_wdata      <= sel_wdata;
                        if (sel_wsize == 2'b00) begin
                            state_reg <= RD_ADDR;
                        end else begin
                            state_reg       <= WR_BUSY;
                            mem_write       <= sel_wsize;
                            timeout_cnt_reg <= '0;
                        end
                    end
                end
                RD_ADDR: begin
                    state_reg <= RD_DATA;
                end
                RD_DATA: begin
                    rdata              <= mem_q;
                    ack_reg[grant_reg] <= ~resp_err;
                    err_reg[grant_reg] <= resp_err;
                    state_reg          <= RESP;
                end
                WR_BUSY: begin
                    // mem_done wins over a timeout landing on the same cycle.
                    if (mem_done || wr_timeout) begin
                        mem_write          <= 2'b00;
                        ack_reg[grant_reg] <= ~resp_err;
                        err_reg[grant_reg] <= resp_err;
                        state_reg          <= RESP;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                        err_flag_reg    <= err_flag_reg | mem_align_error;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    mem_write <= 2'b00;
                end
            endcase
        end
    end

    assign ack0 = ack_reg[0];
    assign ack1 = ack_reg[1];
    assign err0 = err_reg[0];
    assign err1 = err_reg[1];
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, round-robin contention, reads, writes,
// write timeout, alignment error and asynchronous reset in the middle of a write.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  wsize0, wsize1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata, mem_address, mem_wdata, mem_q;
    logic [1:0]  mem_write;
    logic        mem_done, mem_align_error, busy;

    int cmp_cnt  = 0;
    int mism_cnt = 0;
    int wr_cycles;
    int resp_seen;

    mem_port_arbiter #(
        .WORD_SIZE (32),
        .WR_TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (req0),
        .req1           (req1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .wsize0         (wsize0),
        .wsize1         (wsize1),
        .ack0           (ack0),
        .ack1           (ack1),
        .err0           (err0),
        .err1           (err1),
        .rdata          (rdata),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_q          (mem_q),
        .mem_done       (mem_done),
        .mem_align_error(mem_align_error),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mism_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wsize0 = 2'b00; wsize1 = 2'b00;
        mem_q = '0; mem_done = 1'b0; mem_align_error = 1'b0;
        #1 rst = 1'b0;
        #1;
        // Reset takes effect before any clock edge.
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ack_err", {28'h0, ack1, ack0, err1, err0}, 32'h0);

        // Contention: both ports read, requesting from reset.
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h200; addr1 = 32'h300; mem_q = 32'hAAAA_0000;
        tick(2);
        check("held_in_reset_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick(1);
        check("c1_grant_busy", 32'(busy), 32'h1);
        check("c1_grant_port0_addr", mem_address, 32'h200);
        tick(1);
        check("c1_read_mem_write", 32'(mem_write), 32'h0);
        tick(1);
        check("c1_ack0", 32'(ack0), 32'h1);
        check("c1_ack1_quiet", 32'(ack1), 32'h0);
        check("c1_rdata", rdata, 32'hAAAA_0000);
        mem_q = 32'hBBBB_0001;
        tick(1);
        check("c1_idle_gap_busy", 32'(busy), 32'h0);
        check("c1_ack0_one_pulse", 32'(ack0), 32'h0);
        tick(1);
        check("c2_grant_port1_addr", mem_address, 32'h300);
        tick(2);
        check("c2_ack1", 32'(ack1), 32'h1);
        check("c2_ack0_quiet", 32'(ack0), 32'h0);
        check("c2_rdata", rdata, 32'hBBBB_0001);
        tick(2);
        check("c3_grant_port0_addr", mem_address, 32'h200);
        tick(2);
        check("c3_ack0", 32'(ack0), 32'h1);
        tick(2);
        check("c4_grant_port1_addr", mem_address, 32'h300);
        tick(2);
        check("c4_ack1", 32'(ack1), 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        tick(2);
        check("no_req_idle", 32'(busy), 32'h0);

        // Single read from port 0.
        req0 = 1'b1; addr0 = 32'h100; wsize0 = 2'b00; mem_q = 32'hDEAD_BEEF;
        tick(1);
        check("rd_grant_addr", mem_address, 32'h100);
        check("rd_mem_write_a", 32'(mem_write), 32'h0);
        tick(1);
        check("rd_no_early_ack", 32'(ack0), 32'h0);
        tick(1);
        check("rd_ack0", 32'(ack0), 32'h1);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_mem_write_b", 32'(mem_write), 32'h0);
        req0 = 1'b0;
        tick(1);

        // Lone port 0 is granted again although it was served last.
        req0 = 1'b1; addr0 = 32'h140; mem_q = 32'h0BAD_F00D;
        tick(1);
        check("solo_grant_addr", mem_address, 32'h140);
        tick(2);
        check("solo_ack0", 32'(ack0), 32'h1);
        check("solo_rdata", rdata, 32'h0BAD_F00D);
        req0 = 1'b0;
        tick(1);

        // Alignment error reported in RD_DATA.
        req0 = 1'b1; addr0 = 32'h101;
        tick(2);
        mem_align_error = 1'b1;
        tick(1);
        check("align_err0", 32'(err0), 32'h1);
        check("align_no_ack0", 32'(ack0), 32'h0);
        mem_align_error = 1'b0; req0 = 1'b0;
        tick(1);

        // Write from port 1, mem_done in the fifth WR_BUSY cycle.
        req1 = 1'b1; addr1 = 32'h400; wsize1 = 2'b11; wdata1 = 32'h1234_5678; mem_q = 32'h5555_5555;
        tick(1);
        check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        check("wr_mem_address", mem_address, 32'h400);
        wr_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_write == 2'b11) wr_cycles++;
            if (i == 4) mem_done = 1'b1;
            tick(1);
        end
        mem_done = 1'b0;
        check("wr_busy_cycles", 32'(wr_cycles), 32'd5);
        check("wr_ack1", 32'(ack1), 32'h1);
        check("wr_err1_quiet", 32'(err1), 32'h0);
        check("wr_mem_write_off", 32'(mem_write), 32'h0);
        check("wr_rdata_kept", rdata, 32'h0BAD_F00D);
        req1 = 1'b0; wsize1 = 2'b00;
        tick(1);
        check("wr_ack1_one_pulse", 32'(ack1), 32'h0);

        // Write timeout with mem_done held low.
        req0 = 1'b1; addr0 = 32'h500; wsize0 = 2'b01; wdata0 = 32'hCAFE_F00D;
        tick(1);
        wr_cycles = 0; resp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_write == 2'b01) wr_cycles++;
            if (ack0 || err0) resp_seen++;
            tick(1);
        end
        check("to_busy_cycles", 32'(wr_cycles), 32'd8);
        check("to_no_early_resp", 32'(resp_seen), 32'd0);
        check("to_err0", 32'(err0), 32'h1);
        check("to_no_ack0", 32'(ack0), 32'h0);
        check("to_mem_write_off", 32'(mem_write), 32'h0);
        req0 = 1'b0;
        tick(1);

        // Reset two cycles into WR_BUSY; req0 stays pending.
        req0 = 1'b1; addr0 = 32'h600; wsize0 = 2'b10;
        tick(1);
        check("rw_mem_write_c1", 32'(mem_write), 32'h2);
        tick(1);
        check("rw_mem_write_c2", 32'(mem_write), 32'h2);
        #2 rst = 1'b0;
        #1;
        check("rw_async_mem_write", 32'(mem_write), 32'h0);
        check("rw_async_busy", 32'(busy), 32'h0);
        check("rw_rdata_cleared", rdata, 32'h0);
        tick(1);
        check("rw_no_resp", {28'h0, ack1, ack0, err1, err0}, 32'h0);
        rst = 1'b1;
        tick(1);
        check("rw_regrant_busy", 32'(busy), 32'h1);
        check("rw_regrant_addr", mem_address, 32'h600);
        check("rw_regrant_write", 32'(mem_write), 32'h2);
        mem_done = 1'b1;
        tick(1);
        check("rw_ack0", 32'(ack0), 32'h1);
        mem_done = 1'b0; req0 = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
        $finish;
    end
endmodule
